seg7_disp_ctrl: RTL and testbench

Display controller that sequences and feeds the 8-digit 7-segment display driver (Seg7_Dev) on the board. It generates the digit scan index and the blink clock, and holds the driver's Hexs/point/LES/mode inputs in double-buffered registers. The CPU writes those registers over a four-phase handshake, and a debug override can take over the hex content. New content commits only at frame boundaries, so a frame never shows a partial update.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_timer.sv | 65 ++++++
 rtl/seg7_disp_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_disp_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and reset constants for the 7-segment display controller.
package seg7_pkg;

    // Write target selector carried on wr_sel.
    typedef enum logic [1:0] {
        SEL_HEXS  = 2'd0,
        SEL_POINT = 2'd1,
        SEL_LES   = 2'd2,
        SEL_MODE  = 2'd3
    } wr_sel_e;

    // CPU write handshake states.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } wr_state_e;

    // Power-on contents of the driver inputs; shadows reset to the same values.
    localparam logic [31:0] RST_HEXS  = 32'h0000_0000;
    localparam logic [7:0]  RST_POINT = 8'h00;
    localparam logic [7:0]  RST_LES   = 8'h00;
    localparam logic        RST_SW0   = 1'b1;
    localparam logic        RST_FLASH = 1'b1;

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit scan divider, frame counter and blink phase generator.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 131072,
    parameter int unsigned FLASH_FRAMES = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] scan_o,
    output logic       flash_o,
    output logic       frame_end_c
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       scan_q, scan_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             flash_q, flash_d;
    logic             div_wrap;
    logic             frm_wrap;

    assign div_wrap    = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frm_wrap    = (frm_q == FRM_W'(FLASH_FRAMES - 1));
    assign frame_end_c = div_wrap && (scan_q == 3'd7);

    assign scan_o  = scan_q;
    assign flash_o = flash_q;

    // Next-state for divider, digit index, frame count and blink phase.
    always_comb begin
        div_d   = div_q + DIV_W'(1);
        scan_d  = scan_q;
        frm_d   = frm_q;
        flash_d = flash_q;
        if (div_wrap) begin
            div_d  = '0;
            scan_d = scan_q + 3'd1;
        end
        if (frame_end_c) begin
            frm_d = frm_wrap ? '0 : frm_q + FRM_W'(1);
            if (frm_wrap) begin
                flash_d = ~flash_q;
            end
        end
    end

    // Timer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            scan_q  <= 3'd0;
            frm_q   <= '0;
            flash_q <= RST_FLASH;
        end else begin
            div_q   <= div_d;
            scan_q  <= scan_d;
            frm_q   <= frm_d;
            flash_q <= flash_d;
        end
    end

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Double-buffered register front end for the Seg7_Dev display driver.
module seg7_disp_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 131072,
    parameter int unsigned FLASH_FRAMES = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    input  logic        dbg_en,
    input  logic [31:0] dbg_hexs,
    output logic [2:0]  Scan,
    output logic        flash,
    output logic        SW0,
    output logic [31:0] Hexs,
    output logic [7:0]  point,
    output logic [7:0]  LES,
    output logic        frame_start
);

    wr_state_e   state_q, state_d;
    logic        ack_q, ack_d;
    logic        fs_q, fs_d;
    logic        frame_end_c;

    logic [31:0] sh_hexs_q, sh_hexs_d;
    logic [7:0]  sh_point_q, sh_point_d;
    logic [7:0]  sh_les_q, sh_les_d;
    logic        sh_sw0_q, sh_sw0_d;

    logic [31:0] hexs_q, hexs_d;
    logic [7:0]  point_q, point_d;
    logic [7:0]  les_q, les_d;
    logic        sw0_q, sw0_d;

    seg7_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_o      (Scan),
        .flash_o     (flash),
        .frame_end_c (frame_end_c)
    );

    assign wr_ack      = ack_q;
    assign frame_start = fs_q;
    assign Hexs        = hexs_q;
    assign point       = point_q;
    assign LES         = les_q;
    assign SW0         = sw0_q;

    // Write handshake FSM; a shadow is written once, on the IDLE->ACK edge.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        sh_hexs_d  = sh_hexs_q;
        sh_point_d = sh_point_q;
        sh_les_d   = sh_les_q;
        sh_sw0_d   = sh_sw0_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    case (wr_sel_e'(wr_sel))
                        SEL_HEXS:  sh_hexs_d  = wr_data;
                        SEL_POINT: sh_point_d = wr_data[7:0];
                        SEL_LES:   sh_les_d   = wr_data[7:0];
                        SEL_MODE:  sh_sw0_d   = wr_data[0];
                        default:   ;
                    endcase
                end
            end
            ACK: begin
                if (!wr_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame-boundary commit; reads pre-write shadows, debug overrides content.
    always_comb begin
        hexs_d  = hexs_q;
        point_d = point_q;
        les_d   = les_q;
        sw0_d   = sw0_q;
        fs_d    = frame_end_c;
        if (frame_end_c) begin
            if (dbg_en) begin
                hexs_d  = dbg_hexs;
                point_d = 8'h00;
                les_d   = 8'h00;
                sw0_d   = 1'b1;
            end else begin
                hexs_d  = sh_hexs_q;
                point_d = sh_point_q;
                les_d   = sh_les_q;
                sw0_d   = sh_sw0_q;
            end
        end
    end

    // Handshake, shadow and active registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
            sh_hexs_q  <= RST_HEXS;
            sh_point_q <= RST_POINT;
            sh_les_q   <= RST_LES;
            sh_sw0_q   <= RST_SW0;
            hexs_q     <= RST_HEXS;
            point_q    <= RST_POINT;
            les_q      <= RST_LES;
            sw0_q      <= RST_SW0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
            sh_hexs_q  <= sh_hexs_d;
            sh_point_q <= sh_point_d;
            sh_les_q   <= sh_les_d;
            sh_sw0_q   <= sh_sw0_d;
            hexs_q     <= hexs_d;
            point_q    <= point_d;
            les_q      <= les_d;
            sw0_q      <= sw0_d;
        end
    end

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Directed bench for seg7_disp_ctrl with SCAN_DIV=4, FLASH_FRAMES=2 (32-clock frames).
module tb_seg7_disp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        dbg_en;
    logic [31:0] dbg_hexs;
    logic [2:0]  Scan;
    logic        flash;
    logic        SW0;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        frame_start;

    int n_tests;
    int n_fail;
    int cyc;

    seg7_disp_ctrl #(
        .SCAN_DIV     (4),
        .FLASH_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .dbg_en      (dbg_en),
        .dbg_hexs    (dbg_hexs),
        .Scan        (Scan),
        .flash       (flash),
        .SW0         (SW0),
        .Hexs        (Hexs),
        .point       (point),
        .LES         (LES),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_scan"},  32'(Scan), 32'd0);
        chk({tag, "_flash"}, 32'(flash), 32'd1);
        chk({tag, "_sw0"},   32'(SW0), 32'd1);
        chk({tag, "_hexs"},  Hexs, 32'h0);
        chk({tag, "_point"}, 32'(point), 32'h0);
        chk({tag, "_les"},   32'(LES), 32'h0);
        chk({tag, "_ack"},   32'(wr_ack), 32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        wr_req   = 1'b0;
        wr_sel   = 2'd0;
        wr_data  = 32'h0;
        dbg_en   = 1'b0;
        dbg_hexs = 32'h0;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;

        // Test 1: reset then scan/frame timing
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        check_reset_outputs("rst");
        run_to(3);
        chk("scan_c3", 32'(Scan), 32'd0);
        run_to(4);
        chk("scan_c4", 32'(Scan), 32'd1);
        run_to(31);
        chk("scan_c31", 32'(Scan), 32'd7);
        chk("fs_c31", 32'(frame_start), 32'd0);
        run_to(32);
        chk("scan_c32", 32'(Scan), 32'd0);
        chk("fs_c32", 32'(frame_start), 32'd1);
        run_to(33);
        chk("fs_c33", 32'(frame_start), 32'd0);

        // Test 2: Hexs write at clock 5 of the frame
        run_to(37);
        wr_req  = 1'b1;
        wr_sel  = 2'd0;
        wr_data = 32'h1234_5678;
        tick();
        chk("ack_c38", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        tick();
        chk("ack_c39", 32'(wr_ack), 32'd0);
        chk("hexs_c39", Hexs, 32'h0);
        run_to(63);
        chk("hexs_c63", Hexs, 32'h0);
        chk("flash_c63", 32'(flash), 32'd1);
        run_to(64);
        chk("hexs_c64", Hexs, 32'h1234_5678);
        chk("scan_c64", 32'(Scan), 32'd0);
        chk("fs_c64", 32'(frame_start), 32'd1);
        chk("flash_c64", 32'(flash), 32'd0);

        // Test 3: request held after ack must not rewrite
        run_to(66);
        wr_req  = 1'b1;
        wr_data = 32'h1234_5678;
        tick();
        chk("ack_c67", 32'(wr_ack), 32'd1);
        wr_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ack_held", 32'(wr_ack), 32'd0);
        end
        wr_req = 1'b0;
        tick();
        chk("ack_c78", 32'(wr_ack), 32'd0);
        wr_req  = 1'b1;
        wr_sel  = 2'd2;
        wr_data = 32'h0000_000F;
        tick();
        chk("ack_c79", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        run_to(96);
        chk("hexs_c96", Hexs, 32'h1234_5678);
        chk("les_c96", 32'(LES), 32'h0F);

        // Test 4: point write landing on the boundary edge
        run_to(127);
        wr_req  = 1'b1;
        wr_sel  = 2'd1;
        wr_data = 32'h0000_00A5;
        tick();
        chk("ack_c128", 32'(wr_ack), 32'd1);
        chk("point_c128", 32'(point), 32'h00);
        chk("fs_c128", 32'(frame_start), 32'd1);
        chk("flash_c128", 32'(flash), 32'd1);
        wr_req = 1'b0;
        run_to(159);
        chk("point_c159", 32'(point), 32'h00);
        run_to(160);
        chk("point_c160", 32'(point), 32'hA5);

        // Test 5: debug override and restore
        dbg_en   = 1'b1;
        dbg_hexs = 32'hDEAD_BEEF;
        run_to(191);
        chk("hexs_c191", Hexs, 32'h1234_5678);
        run_to(192);
        chk("dbg_hexs", Hexs, 32'hDEAD_BEEF);
        chk("dbg_point", 32'(point), 32'h00);
        chk("dbg_les", 32'(LES), 32'h00);
        chk("dbg_sw0", 32'(SW0), 32'd1);
        chk("flash_c192", 32'(flash), 32'd0);
        dbg_en = 1'b0;
        run_to(224);
        chk("rest_hexs", Hexs, 32'h1234_5678);
        chk("rest_les", 32'(LES), 32'h0F);
        chk("rest_point", 32'(point), 32'hA5);
        chk("rest_sw0", 32'(SW0), 32'd1);
        wr_req  = 1'b1;
        wr_sel  = 2'd3;
        wr_data = 32'h0000_0000;
        tick();
        chk("ack_c225", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        run_to(256);
        chk("mode_sw0", 32'(SW0), 32'd0);
        chk("flash_c256", 32'(flash), 32'd1);

        // Test 6: reset mid-frame with a request pending
        run_to(260);
        wr_req  = 1'b1;
        wr_sel  = 2'd0;
        wr_data = 32'h0000_0055;
        tick();
        chk("ack_c261", 32'(wr_ack), 32'd1);
        chk("scan_c261", 32'(Scan), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        wr_req = 1'b0;
        rst_n  = 1'b1;
        cyc    = 0;
        run_to(32);
        chk("post_rst_hexs", Hexs, 32'h0);
        chk("post_rst_sw0", 32'(SW0), 32'd1);
        chk("post_rst_fs", 32'(frame_start), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
